// File: rtl/tx_symbol_mux_rr.sv
// Registered N-channel Tx symbol multiplexer: fixed-select or round-robin grant, valid/ready on all sides.
// Optional build macro TXMUX_PARITY_EN adds a registered even-parity output out_par.
module tx_symbol_mux_rr #(
    parameter  int W  = 2,
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
`ifdef TXMUX_PARITY_EN
    ,
    output logic           out_par
`endif
);

    logic          load;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    int            rr_idx;

    assign load = !out_valid || out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        rr_idx     = 0;
        if (!mode) begin
            // sel values with no matching channel simply never grant
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = in_data[i*W +: W];
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                rr_idx = (int'(ptr) + k) % N;
                if (!grant_vld && in_valid[rr_idx]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SW'(rr_idx);
                    grant_data = in_data[rr_idx*W +: W];
                end
            end
        end
    end

    assign ptr_next = (grant_idx == SW'(N-1)) ? '0 : grant_idx + 1'b1;

    // in_ready is forced low while reset is asserted, independent of the clock
    always_comb begin
        in_ready = '0;
        if (rst_n && load && grant_vld)
            in_ready[grant_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_vld) begin
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                if (mode)
                    ptr <= ptr_next;
            end else begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TXMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_par <= 1'b0;
        else if (load)
            out_par <= grant_vld ? ^grant_data : 1'b0;
    end
`endif

endmodule
